// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode field, NOP-class opcodes, bubble
// encoding and the fetch FSM state encoding.
package pipeline_pkg;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  // Opcodes that need the NOP counter to insert bubbles after them
  localparam logic [OPCODE_W-1:0] NOP_CLASS_OPCODES [2] = '{4'hE, 4'hF};

  // A bubble is an all-zero instruction word with the valid bit clear
  localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    RUN    = 2'd2
  } fetch_state_t;

  function automatic logic is_nop_class(input logic [OPCODE_W-1:0] opcode);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < $size(NOP_CLASS_OPCODES); i++) begin
      if (opcode == NOP_CLASS_OPCODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port plus the IF/ID register
// outputs. The fetch stage is the master, memory/decode side the slave.
interface fetch_stage_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 16
);

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;
  logic               ifid_valid;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output ifid_instr,
    output ifid_pc,
    output ifid_valid
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_valid
  );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with bubble, load and hold controls.
// Bubble has priority over load; with neither asserted the register holds.
module ifid_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid
);

  // Capture, squash or hold the instruction handed to decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else if (bubble) begin
      ifid_instr <= INSTR_W'(BUBBLE_INSTR);
      ifid_valid <= 1'b0;
    end else if (load) begin
      ifid_instr <= instr_in;
      ifid_pc    <= pc_in;
      ifid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, optional reset-vector load FSM, NOP trigger
// and the IF/ID register. Define RESET_VECTOR_EN to load the start PC from
// memory words 0 (low half) and 1 (high half) after reset; otherwise the
// stage starts fetching at RESET_PC straight out of reset.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_nop,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   branch_target,
  output logic              nop_trigger,
  fetch_stage_if.master     bus
);

`ifdef RESET_VECTOR_EN
  localparam logic [PC_W-1:0] PC_RESET_VAL = '0;
`else
  localparam logic [PC_W-1:0] PC_RESET_VAL = RESET_PC;
`endif

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] imem_addr_c;
  logic            ifid_load;
  logic            ifid_bubble;
  logic            trig_next;
  fetch_state_t    state;

`ifdef RESET_VECTOR_EN
  fetch_state_t    state_next;

  // FSM state register: every reset restarts the vector load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= VEC_LO;
    else        state <= state_next;
  end

  // Next-state logic: walk the two vector words, stall freezes the walk
  always_comb begin
    state_next = state;
    case (state)
      VEC_LO:  if (!stall) state_next = VEC_HI;
      VEC_HI:  if (!stall) state_next = RUN;
      default: state_next = RUN;
    endcase
  end
`else
  assign state = RUN;
`endif

  // Output logic: PC update, IF/ID control and trigger for this edge
  always_comb begin
    pc_next     = pc;
    imem_addr_c = pc;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    trig_next   = 1'b0;
    case (state)
`ifdef RESET_VECTOR_EN
      VEC_LO: begin
        if (!stall) pc_next = PC_W'(imem_rdata_lo());
      end
      VEC_HI: begin
        imem_addr_c = PC_W'(1);
        if (!stall) pc_next = PC_W'({bus.imem_rdata, pc[15:0]});
      end
`endif
      RUN: begin
        if (flush) begin
          pc_next     = branch_target;
          ifid_bubble = 1'b1;
        end else if (stall) begin
          pc_next = pc;
        end else if (fetch_nop) begin
          ifid_bubble = 1'b1;
        end else begin
          pc_next   = pc + PC_W'(1);
          ifid_load = 1'b1;
          // the cycle after a trigger never re-triggers
          trig_next = is_nop_class(bus.imem_rdata[OPCODE_MSB:OPCODE_LSB]) && !nop_trigger;
        end
      end
      default: pc_next = pc;
    endcase
  end

`ifdef RESET_VECTOR_EN
  function automatic logic [INSTR_W-1:0] imem_rdata_lo();
    return bus.imem_rdata;
  endfunction
`endif

  assign bus.imem_addr = imem_addr_c;

  // Program counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= PC_RESET_VAL;
    else        pc <= pc_next;
  end

  // One-cycle pulse to the NOP counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) nop_trigger <= 1'b0;
    else        nop_trigger <= trig_next;
  end

  ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .instr_in   (bus.imem_rdata),
    .pc_in      (pc + PC_W'(1)),
    .ifid_instr (bus.ifid_instr),
    .ifid_pc    (bus.ifid_pc),
    .ifid_valid (bus.ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// control traffic compared against a behavioural model of the fetch rules.
// Honours RESET_VECTOR_EN the same way the design does.
module tb_fetch_stage;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_nop;
  logic              stall;
  logic              flush;
  logic [PC_W-1:0]   branch_target;
  logic              nop_trigger;
  logic [15:0]       mem [256];

  int assert_count = 0;
  int fail_count   = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_ifid_pc;
  logic [15:0] m_instr;
  logic        m_valid;
  logic        m_trig;
  int          vec_phase;

  fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  assign bus.imem_rdata = mem[bus.imem_addr[7:0]];

  fetch_stage #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_nop     (fetch_nop),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .nop_trigger   (nop_trigger),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] model_addr();
    return (vec_phase == 1) ? 32'd1 : m_pc;
  endfunction

  function automatic logic nop_opcode(input logic [15:0] w);
    return (w[15:12] == 4'hE) || (w[15:12] == 4'hF);
  endfunction

  task automatic model_reset();
    m_pc      = 32'h0;
    m_ifid_pc = 32'h0;
    m_instr   = 16'h0;
    m_valid   = 1'b0;
    m_trig    = 1'b0;
`ifdef RESET_VECTOR_EN
    vec_phase = 0;
`else
    vec_phase = 2;
`endif
  endtask

  // One rising edge of the specified behaviour, given current inputs
  task automatic model_edge();
    logic [15:0] fetched;
    fetched = mem[model_addr() & 32'hFF];
    if (vec_phase == 0) begin
      m_trig = 1'b0;
      if (!stall) begin m_pc = {16'h0, fetched}; vec_phase = 1; end
    end else if (vec_phase == 1) begin
      m_trig = 1'b0;
      if (!stall) begin m_pc = {fetched, m_pc[15:0]}; vec_phase = 2; end
    end else if (flush) begin
      m_pc = branch_target; m_instr = 16'h0; m_valid = 1'b0; m_trig = 1'b0;
    end else if (stall) begin
      m_trig = 1'b0;
    end else if (fetch_nop) begin
      m_instr = 16'h0; m_valid = 1'b0; m_trig = 1'b0;
    end else begin
      m_instr   = fetched;
      m_ifid_pc = m_pc + 32'd1;
      m_valid   = 1'b1;
      m_trig    = nop_opcode(fetched) && !m_trig;
      m_pc      = m_pc + 32'd1;
    end
  endtask

  task automatic check_all(input string tag);
    check_output({tag, "_imem_addr"}, bus.imem_addr, model_addr());
    check_output({tag, "_ifid_valid"}, 32'(bus.ifid_valid), 32'(m_valid));
    check_output({tag, "_ifid_instr"}, 32'(bus.ifid_instr), 32'(m_instr));
    check_output({tag, "_nop_trigger"}, 32'(nop_trigger), 32'(m_trig));
    if (m_valid) check_output({tag, "_ifid_pc"}, bus.ifid_pc, m_ifid_pc);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_imem_addr"}, bus.imem_addr, 32'h0);
    check_output({tag, "_ifid_valid"}, 32'(bus.ifid_valid), 32'h0);
    check_output({tag, "_ifid_instr"}, 32'(bus.ifid_instr), 32'h0);
    check_output({tag, "_ifid_pc"}, bus.ifid_pc, 32'h0);
    check_output({tag, "_nop_trigger"}, 32'(nop_trigger), 32'h0);
  endtask

  // Drive one cycle of controls, advance model and DUT, then compare
  task automatic apply_stimulus(input logic f_nop, input logic st, input logic fl,
                                input logic [31:0] tgt, input string tag);
    fetch_nop     = f_nop;
    stall         = st;
    flush         = fl;
    branch_target = tgt;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_values(tag);
    fetch_nop = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    fetch_nop = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
    mem[5] = 16'hE005;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b1;

`ifdef RESET_VECTOR_EN
    mem[0]    = 16'h1234;
    mem[1]    = 16'h0000;
    mem[8'h34] = 16'h0ABC;
    apply_stimulus(0, 0, 0, 0, "vec_edge1");
    apply_stimulus(0, 0, 0, 0, "vec_edge2");
    apply_stimulus(0, 0, 0, 0, "vec_edge3");
    check_output("vec_first_valid", 32'(bus.ifid_valid), 32'h1);
    check_output("vec_first_instr", 32'(bus.ifid_instr), 32'h0ABC);
    check_output("vec_first_pc", bus.ifid_pc, 32'h1235);
    // restart in the middle of a vector load
    apply_stimulus(0, 1, 0, 0, "vec_stall_pre");
    async_reset("reset_pre_vec");
    apply_stimulus(0, 0, 0, 0, "vec_mid");
    async_reset("reset_mid_vec");
    apply_stimulus(0, 0, 0, 0, "vec_again1");
    apply_stimulus(0, 0, 0, 0, "vec_again2");
`else
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 0, 0, 0, "seq_fetch");
      check_output("seq_instr", 32'(bus.ifid_instr), 32'h100 + 32'(k));
      check_output("seq_pc", bus.ifid_pc, 32'(k + 1));
    end
    apply_stimulus(0, 0, 0, 0, "fetch3");
    apply_stimulus(0, 0, 0, 0, "fetch4");
    apply_stimulus(0, 0, 0, 0, "fetch5");
    check_output("nop_trig_set", 32'(nop_trigger), 32'h1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1, 0, 0, 0, "nop_bubble");
      check_output("nop_trig_pulse", 32'(nop_trigger), 32'h0);
      check_output("nop_bubble_valid", 32'(bus.ifid_valid), 32'h0);
      check_output("nop_pc_hold", bus.imem_addr, 32'h6);
    end
`endif

    apply_stimulus(0, 1, 1, 32'h40, "flush_stall");
    check_output("flush_valid", 32'(bus.ifid_valid), 32'h0);
    check_output("flush_addr", bus.imem_addr, 32'h40);
    apply_stimulus(0, 0, 0, 0, "after_flush");

    apply_stimulus(0, 0, 1, 32'hFFFF_FFFF, "to_top");
    apply_stimulus(0, 0, 0, 0, "wrap");
    check_output("wrap_ifid_pc", bus.ifid_pc, 32'h0);
    check_output("wrap_addr", bus.imem_addr, 32'h0);

    apply_stimulus(0, 1, 0, 0, "stall_a");
    apply_stimulus(0, 1, 0, 0, "stall_b");
    async_reset("reset_mid_stall");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] tgt;
      logic [15:0] w;
      if (n % 50 == 0) begin
        for (int i = 0; i < 256; i++) begin
          w = 16'($urandom);
          if ($urandom_range(0, 3) == 0) w[15:12] = 4'hE + 4'($urandom_range(0, 1));
          mem[i] = w;
        end
      end
      tgt = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
      apply_stimulus($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                     $urandom_range(0, 99) < 10, tgt, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter width (word address).
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC loaded at reset when vector load is compiled out.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port fetch_nop  input  1  NOP-insertion request from the NOP counter.
REQ-007 SHALL have port stall  input  1  hold request from the hazard unit.
REQ-008 SHALL have port flush  input  1  taken-branch redirect.
REQ-009 SHALL have port branch_target  input  PC_W  redirect address, valid with flush.
REQ-010 SHALL have port imem_addr  output  PC_W  instruction-memory address; equals the current PC.
REQ-011 SHALL have port imem_rdata  input  INSTR_W  instruction word, combinational from imem_addr in the same cycle.
REQ-012 SHALL have port ifid_instr  output  INSTR_W  IF/ID instruction register.
REQ-013 SHALL have port ifid_pc  output  PC_W  IF/ID register, PC+1 of the captured instruction.
REQ-014 SHALL have port ifid_valid  output  1  IF/ID holds a real instruction, not a bubble.
REQ-015 SHALL have port nop_trigger  output  1  one-cycle pulse to the NOP counter write_enable.

Function
REQ-016 SHALL implement FSM states VEC_LO, VEC_HI and RUN; only RUN fetches instructions.
REQ-017 SHALL encode a bubble as ifid_instr=0, ifid_valid=0.
REQ-018 SHALL apply the following per-edge priority in RUN: flush > stall > fetch_nop > normal fetch.
REQ-019 SHALL, on flush: PC<=branch_target, IF/ID<=bubble, nop_trigger<=0; flush overrides a simultaneous stall.
REQ-020 SHALL, on stall without flush: hold PC, IF/ID and ifid_valid unchanged, nop_trigger<=0.
REQ-021 SHALL, on fetch_nop without flush or stall: hold PC, IF/ID<=bubble, nop_trigger<=0.
REQ-022 SHALL, on normal fetch: ifid_instr<=imem_rdata, ifid_pc<=PC+1, ifid_valid<=1, PC<=PC+1.
REQ-023 SHALL increment the PC modulo 2^PC_W, wrapping from all-ones to 0 with no flag.
REQ-024 SHALL set nop_trigger<=1 on a normal fetch whose imem_rdata opcode field is in the NOP class, and <=0 otherwise.
REQ-025 SHALL never assert nop_trigger for two consecutive cycles.
REQ-026 SHALL give a 1-cycle latency from a normal fetch at PC=p to ifid_instr=mem[p].

Reset
REQ-027 SHALL, while reset=0, force ifid_instr=0, ifid_pc=0, ifid_valid=0, nop_trigger=0 and imem_addr=PC reset value, independent of clk.
REQ-028 SHALL treat assertion of reset in any state, including mid-vector-load, as a full restart.

Configuration
REQ-029 SHALL, with RESET_VECTOR_EN defined, leave reset into VEC_LO with PC=0, capture imem_rdata into PC[15:0] and set imem_addr=1, move to VEC_HI, capture PC[31:16], then enter RUN; ifid_valid stays 0.
REQ-030 SHALL, during VEC_LO/VEC_HI, ignore flush and fetch_nop; stall holds the FSM state.
REQ-031 SHALL, without RESET_VECTOR_EN, leave reset directly into RUN with PC=RESET_PC; VEC_LO/VEC_HI are not generated.

Structure
REQ-032 SHALL take the opcode field position, NOP-class opcode list, bubble encoding and FSM state encoding from shared package pipeline_pkg.
REQ-033 SHALL place the IF/ID register in sub-module ifid_reg (load, bubble, hold controls); the PC, FSM and trigger logic stay in fetch_stage.

Verification
REQ-034 SHALL cover: RESET_PC=0, no controls, mem[k]=k+0x100 -> ifid_instr 0x100,0x101,0x102 on cycles 1-3 after reset release, ifid_pc 1,2,3.
REQ-035 SHALL cover: fetch at PC=5 with NOP-class opcode -> nop_trigger=1 for exactly 1 cycle; then fetch_nop=1 for 3 cycles -> 3 bubbles, PC held at 6.
REQ-036 SHALL cover: flush=1 and stall=1 together, branch_target=0x40 -> next ifid_valid=0, imem_addr=0x40.
REQ-037 SHALL cover: PC=0xFFFFFFFF normal fetch -> ifid_pc=0, imem_addr=0.
REQ-038 SHALL cover, with RESET_VECTOR_EN: mem[0]=0x1234, mem[1]=0x0000 -> first valid instruction fetched from 0x1234 on the third edge after release.
REQ-039 SHALL cover: reset=0 asserted asynchronously mid-stall and mid-vector-load -> all outputs at reset values before the next clk edge.
